token_arbiter: RTL and testbench
================================

# token_arbiter

Multi-channel token scheduler that shares a single serial output line between `N_CH` serial token inputs. Each '1' token arriving on channel `i` credits that channel with `MULT` output tokens. A round-robin arbiter drains the per-channel credit counters onto `b`, one token per cycle, and tags each token with its source channel on `b_ch`. The block sits in front of the token-expansion datapath. It generalises single-stream doubling to several requesters contending for one output, with per-channel sticky overflow.

## Interface
- `N_CH`, default 4: number of input channels, range 2..16.
- `MULT`, default 2: output tokens credited per input token, range 1..8.
- `MAX_PEND`, default 200: maximum credits a channel may hold.
- `CNT_W`, localparam `$clog2(MAX_PEND+MULT+1)`: credit counter width.
- `ID_W`, localparam `$clog2(N_CH)`: channel-id width.
- `clk`, input, 1: single clock; all state on rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `a`, input, `N_CH`: serial token inputs; `a[i]`=1 is one token on channel `i`, sampled every edge.
- `b`, output, 1: serial output token.
- `b_ch`, output, `ID_W`: channel that owns the current `b` token; 0 when `b`=0.
- `overflow`, output, `N_CH`: per-channel sticky overflow flag.
- `idle`, output, 1: all credit counters are zero and `b`=0.

## Operation
- Per channel `i`, credit counter `pend[i]`. Each edge: `pend[i] <= sat(pend[i] + (a[i] ? MULT : 0) - (gnt[i] ? 1 : 0))`.
- Simultaneous arrival and grant on the same channel: net change is `MULT-1` in one update, with no lost or duplicated token.
- Saturation: if the unsaturated sum exceeds `MAX_PEND`, `pend[i]` becomes `MAX_PEND`, excess tokens are dropped, and `overflow[i]` is set.
  - `overflow[i]` is cleared only by `rst_n`.
  - A channel in overflow keeps arbitrating normally.
- Arbitration:
  - Combinational request `req[i] = (pend[i] != 0)`, computed from registered counters.
  - Round-robin pointer `last` holds the last granted channel. Search order is `last+1, last+2, ...` modulo `N_CH`.
  - The first requester found is granted and `last` is updated to it.
  - No request: no grant and `last` holds.
  - At most one grant per cycle.
- Output: `b <= |gnt`, `b_ch <= index(gnt)`, both registered.
- Arithmetic is unsigned. `CNT_W` guarantees `MAX_PEND+MULT` is representable, so no wrap is possible before saturation.
- `idle = (pend == 0 for all i) && !b`.

## Timing
- Reset values (asynchronous, on `rst_n`=0):
  - `pend`=0, `overflow`=0, `b`=0, `b_ch`=0, `idle`=1.
  - `last`=`N_CH-1`, so channel 0 has first priority.
- Reset asserted mid-operation: all pending credits are discarded immediately. No token appears on `b` after deassertion until new input arrives.
- Latency:
  - Token on `a[i]` sampled at edge k updates `pend[i]` at edge k.
  - First `b` pulse appears after edge k+1, when the channel is uncontended.
- Throughput: one output token per cycle, maximum. Sustained input above 1/`MULT` tokens per cycle aggregate accumulates credits.
- Single channel, `MULT`=2, isolated token at edge k: `b`=1 after edges k+1 and k+2, then 0.
- Contended channels are served strictly alternately. A requester waits at most `N_CH-1` cycles between grants.

## Configuration
- `TOKEN_ARB_DROP_CNT_EN` defined:
  - Adds output port `drop_cnt [15:0]`, the total number of dropped credits across all channels.
  - Saturates at 16'hFFFF; reset value 0; cleared only by `rst_n`.
  - Increments by the number of excess credits discarded in that cycle, summed over channels.
- Not defined: port and counter are absent. Overflow behaviour is otherwise identical.

## Structure
- Package `token_arb_pkg`: default values for `N_CH`, `MULT` and `MAX_PEND`, plus a function returning the clamped `pend` next value and an overflow bit.
- Sub-module `rr_arbiter`:
  - Parameter `N`.
  - Ports `clk`, `rst_n`, `req[N]`, `gnt[N]` (one-hot, combinational), `gnt_id[$clog2(N)]`, `gnt_vld`.
  - Owns the `last` pointer.
- The top level holds the counters, overflow flags, output registers and the optional drop counter.

## Test plan
- Defaults; `a[0]`=1 for one cycle after reset: `b`=1 for exactly 2 cycles starting 2 edges later, `b_ch`=0, then `idle`=1.
- `a[0]` and `a[2]` pulsed in the same cycle: `b_ch` sequence is 0,2,0,2 and `b` stays high for 4 consecutive cycles.
- `a[1]` held high for 300 cycles: `pend[1]` stays ≤200, `overflow[1]` rises and stays set after `a` drops. Other `overflow` bits remain 0. With `TOKEN_ARB_DROP_CNT_EN` defined, `drop_cnt` equals the exact dropped count computed by the model.
- `a[3]` high on the same cycle `pend[3]`=1 is being granted: `pend[3]` becomes 2 (`1+2-1`), and the total `b` tokens for channel 3 equal 2×(input tokens).
- `rst_n` pulsed low while `pend[0]`=50: `b`=0 and `overflow`=0 immediately; no `b` pulse after release until a new `a` token arrives.
- Random `a` traffic for 10k cycles below the overflow threshold, checked against a scoreboard:
  - Total `b` tokens per channel equal `MULT`×inputs.
  - No channel waits more than `N_CH-1` cycles while requesting.

Source files
------------

// File: rtl/token_arb_pkg.sv
// Shared defaults and the saturating credit-update helper for token_arbiter.
package token_arb_pkg;

    localparam int N_CH_DEF     = 4;
    localparam int MULT_DEF     = 2;
    localparam int MAX_PEND_DEF = 200;

    // The result is kept 32 bits wide so one helper serves every parameter set.
    // The caller truncates it to the counter width.
    typedef struct packed {
        logic        ovf;
        logic [31:0] val;
        logic [31:0] drop;
    } clamp_t;

    function automatic clamp_t clamp_pend(input logic [31:0] sum, input logic [31:0] max_pend);
        clamp_t r;
        r.ovf  = (sum > max_pend);
        r.val  = r.ovf ? max_pend : sum;
        r.drop = r.ovf ? (sum - max_pend) : 32'd0;
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter. It owns the last-granted pointer and produces a combinational
// one-hot grant. The search starts one channel past the previous winner.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_id,
    output logic          gnt_vld
);

    logic [IW-1:0] last;
    logic [IW-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        gnt_vld = 1'b0;
        idx     = '0;
        for (int off = 1; off <= N; off++) begin
            idx = IW'((int'(last) + off) % N);
            if (!gnt_vld && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_id   = idx;
                gnt_vld  = 1'b1;
            end
        end
    end

    // Resetting to the top index makes channel 0 the first in line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       last <= IW'(N - 1);
        else if (gnt_vld) last <= gnt_id;
    end

endmodule

// File: rtl/token_arbiter.sv
// Multi-channel token scheduler: per-channel saturating credit counters drained by RR onto b.
// Optional TOKEN_ARB_DROP_CNT_EN adds a saturating count of dropped credits (drop_cnt).
module token_arbiter
    import token_arb_pkg::*;
#(
    parameter  int N_CH     = N_CH_DEF,
    parameter  int MULT     = MULT_DEF,
    parameter  int MAX_PEND = MAX_PEND_DEF,
    localparam int CNT_W    = $clog2(MAX_PEND + MULT + 1),
    localparam int ID_W     = $clog2(N_CH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] a,
    output logic            b,
    output logic [ID_W-1:0] b_ch,
    output logic [N_CH-1:0] overflow,
    output logic            idle
`ifdef TOKEN_ARB_DROP_CNT_EN
    ,
    output logic [15:0]     drop_cnt
`endif
);

    logic [N_CH-1:0][CNT_W-1:0] pend;
    logic [N_CH-1:0]            req;
    logic [N_CH-1:0]            gnt;
    logic [ID_W-1:0]            gnt_id;
    logic                       gnt_vld;
    clamp_t                     nxt [N_CH];
    logic                       unused_clamp;

    always_comb begin
        unused_clamp = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            req[i] = (pend[i] != '0);
            // Arrival and grant are folded into one update, so a simultaneous pair nets MULT-1.
            nxt[i] = clamp_pend(32'(pend[i]) + (a[i] ? 32'(MULT) : 32'd0) - (gnt[i] ? 32'd1 : 32'd0),
                                32'(MAX_PEND));
            unused_clamp = unused_clamp ^ (^nxt[i]);
        end
    end

    rr_arbiter #(.N(N_CH)) u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .gnt_vld (gnt_vld)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend     <= '0;
            overflow <= '0;
            b        <= 1'b0;
            b_ch     <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                pend[i] <= CNT_W'(nxt[i].val);
                if (nxt[i].ovf) overflow[i] <= 1'b1;
            end
            b    <= gnt_vld;
            b_ch <= gnt_id;
        end
    end

    assign idle = (pend == '0) && !b;

`ifdef TOKEN_ARB_DROP_CNT_EN
    // At most MULT credits drop per channel per cycle, so 8 bits cover 16 channels x 8.
    logic [7:0]  drop_sum;
    logic [16:0] drop_acc;

    always_comb begin
        drop_sum = '0;
        for (int i = 0; i < N_CH; i++) drop_sum = drop_sum + 8'(nxt[i].drop);
        drop_acc = {1'b0, drop_cnt} + {9'd0, drop_sum};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) drop_cnt <= '0;
        else        drop_cnt <= drop_acc[16] ? 16'hFFFF : drop_acc[15:0];
    end
`endif

endmodule

// File: tb/tb_token_arbiter.sv
// Self-checking bench for token_arbiter (default parameters): vector table plus corner sequences.
module tb_token_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] a;
    logic       b;
    logic [1:0] b_ch;
    logic [3:0] overflow;
    logic       idle;
`ifdef TOKEN_ARB_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    int total = 0;
    int bad   = 0;

    token_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a),
        .b        (b),
        .b_ch     (b_ch),
        .overflow (overflow),
        .idle     (idle)
`ifdef TOKEN_ARB_DROP_CNT_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [3:0] a;
        logic       b;
        logic [1:0] b_ch;
        logic       idle;
        logic [3:0] ovf;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic r, logic [3:0] av, logic eb, logic [1:0] ec, logic ei, logic [3:0] eo);
        vec_t v;
        v.rst_n = r; v.a = av; v.b = eb; v.b_ch = ec; v.idle = ei; v.ovf = eo;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Inputs change at the falling edge; outputs are sampled one full falling edge later.
    task automatic step(input logic r, input logic [3:0] av);
        rst_n = r;
        a     = av;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int p, drops, bcnt, n;
        int mp[4], inc[4], got[4], wt[4];
        bit reqp[4];
        int maxw, bad_ch;
        logic [3:0] av;

        rst_n = 1'b0;
        a     = '0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_b", b, 0);
        chk("reset_b_ch", b_ch, 0);
        chk("reset_ovf", overflow, 0);
        chk("reset_idle", idle, 1);
`ifdef TOKEN_ARB_DROP_CNT_EN
        chk("reset_drop_cnt", drop_cnt, 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // Single isolated token on ch0: two b pulses two edges after arrival.
        vt.push_back(mk(1, 4'b0001, 0, 0, 0, 0));
        vt.push_back(mk(1, 4'b0000, 1, 0, 0, 0));
        vt.push_back(mk(1, 4'b0000, 1, 0, 0, 0));
        vt.push_back(mk(1, 4'b0000, 0, 0, 1, 0));
        vt.push_back(mk(1, 4'b0000, 0, 0, 1, 0));
        // Contention between ch0 and ch2 from a fresh pointer: 0,2,0,2.
        vt.push_back(mk(0, 4'b0000, 0, 0, 1, 0));
        vt.push_back(mk(1, 4'b0101, 0, 0, 0, 0));
        vt.push_back(mk(1, 4'b0000, 1, 0, 0, 0));
        vt.push_back(mk(1, 4'b0000, 1, 2, 0, 0));
        vt.push_back(mk(1, 4'b0000, 1, 0, 0, 0));
        vt.push_back(mk(1, 4'b0000, 1, 2, 0, 0));
        vt.push_back(mk(1, 4'b0000, 0, 0, 1, 0));
        // Arrival on ch3 while its last credit is granted: 4 tokens total for 2 inputs.
        vt.push_back(mk(0, 4'b0000, 0, 0, 1, 0));
        vt.push_back(mk(1, 4'b1000, 0, 0, 0, 0));
        vt.push_back(mk(1, 4'b0000, 1, 3, 0, 0));
        vt.push_back(mk(1, 4'b1000, 1, 3, 0, 0));
        vt.push_back(mk(1, 4'b0000, 1, 3, 0, 0));
        vt.push_back(mk(1, 4'b0000, 1, 3, 0, 0));
        vt.push_back(mk(1, 4'b0000, 0, 0, 1, 0));

        foreach (vt[i]) begin
            step(vt[i].rst_n, vt[i].a);
            chk($sformatf("vec%0d_b", i), b, vt[i].b);
            chk($sformatf("vec%0d_b_ch", i), b_ch, vt[i].b_ch);
            chk($sformatf("vec%0d_idle", i), idle, vt[i].idle);
            chk($sformatf("vec%0d_ovf", i), overflow, vt[i].ovf);
        end

        // Overflow: ch1 held high for 300 cycles against a one-channel model.
        step(0, 4'b0000);
        p = 0; drops = 0; bcnt = 0;
        for (int i = 0; i < 300; i++) begin
            int s;
            s = p + 2 - ((p != 0) ? 1 : 0);
            if (s > 200) begin drops += s - 200; s = 200; end
            p = s;
            step(1, 4'b0010);
            if (b) bcnt++;
        end
        chk("ovf_flags", overflow, 4'b0010);
`ifdef TOKEN_ARB_DROP_CNT_EN
        chk("ovf_drop_cnt", drop_cnt, drops);
`endif
        n = 0;
        while (!idle && n < 400) begin
            step(1, 4'b0000);
            if (b) bcnt++;
            n++;
        end
        chk("ovf_drained_idle", idle, 1);
        chk("ovf_total_b", bcnt, 600 - drops);
        chk("ovf_sticky", overflow, 4'b0010);

        // Asynchronous reset while ch0 holds 50 credits.
        for (int i = 0; i < 49; i++) step(1, 4'b0001);
        a = 4'b0000;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_b", b, 0);
        chk("arst_ovf", overflow, 0);
        chk("arst_idle", idle, 1);
        @(negedge clk);
        bcnt = 0;
        for (int i = 0; i < 20; i++) begin
            step(1, 4'b0000);
            if (b) bcnt++;
        end
        chk("arst_no_stale_b", bcnt, 0);
        step(1, 4'b0001);
        bcnt = 0;
        for (int i = 0; i < 5; i++) begin
            step(1, 4'b0000);
            if (b) bcnt++;
        end
        chk("arst_new_token_b", bcnt, 2);

        // Random traffic with a credit scoreboard and a fairness monitor.
        step(0, 4'b0000);
        foreach (mp[i]) begin mp[i] = 0; inc[i] = 0; got[i] = 0; wt[i] = 0; reqp[i] = 0; end
        maxw = 0; bad_ch = 0; n = 0;
        for (int c = 0; c < 11000; c++) begin
            if (c >= 10000 && idle) break;
            for (int i = 0; i < 4; i++) av[i] = (c < 10000) && ($urandom_range(0, 15) == 0);
            step(1, av);
            for (int i = 0; i < 4; i++) if (av[i]) begin mp[i] += 2; inc[i]++; end
            if (b) begin got[b_ch]++; mp[b_ch]--; end
            else if (b_ch != 0) bad_ch++;
            for (int i = 0; i < 4; i++) begin
                if (reqp[i] && !(b && b_ch == 2'(i))) wt[i]++;
                else wt[i] = 0;
                if (wt[i] > maxw) maxw = wt[i];
                reqp[i] = (mp[i] > 0);
            end
        end
        chk("rand_drained_idle", idle, 1);
        chk("rand_b_ch_zero_when_idle", bad_ch, 0);
        chk("rand_no_overflow", overflow, 0);
        for (int i = 0; i < 4; i++) chk($sformatf("rand_tokens_ch%0d", i), got[i], 2 * inc[i]);
        total++;
        if (maxw > 3) begin
            bad++;
            $display("FAIL rand_rr_wait: max wait %0d cycles, limit 3", maxw);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
